// File: rtl/count_sequencer.sv
// count_sequencer: sequences an external ripple counter through clear, settle, check and tick phases.
// Define CNT_CHECK_EN to synchronise cnt_q and flag readback mismatches on err.
module count_sequencer #(
    parameter int WIDTH      = 4,
    parameter int SETTLE_CYC = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] tc,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_clr,
    output logic             cnt_tick,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int WAIT_W = $clog2(SETTLE_CYC);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT,
        CHECK,
        TICK,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
    logic [WIDTH-1:0]  tcCap_q, tcCap_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic              clr_q, clr_d;
    logic              tick_q, tick_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              readbackBad;

`ifdef CNT_CHECK_EN
    logic [WIDTH-1:0] sync1_q, sync2_q;

    // cnt_q ripples asynchronously to clk, so it is resampled twice before use.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= cnt_q;
            sync2_q <= sync1_q;
        end
    end

    assign readbackBad = (sync2_q != count_q);
`else
    logic unused_cntQ;

    assign unused_cntQ = ^cnt_q;
    assign readbackBad = 1'b0;
`endif

    // Strobes are registered from the state they belong to, so each appears one
    // clock after its state; stop suppresses them together with the transition.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        tcCap_d   = tcCap_q;
        count_d   = count_q;
        err_d     = err_q;
        clr_d     = 1'b0;
        tick_d    = 1'b0;
        done_d    = 1'b0;

        if (state_q != IDLE && stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        tcCap_d = tc;
                        count_d = '0;
                        err_d   = 1'b0;
                        state_d = CLEAR;
                    end
                end
                CLEAR: begin
                    clr_d     = 1'b1;
                    waitCnt_d = '0;
                    state_d   = WAIT;
                end
                WAIT: begin
                    if (waitCnt_q == WAIT_LAST) begin
                        state_d = CHECK;
                    end else begin
                        waitCnt_d = waitCnt_q + 1'b1;
                    end
                end
                CHECK: begin
                    if (readbackBad) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (count_q == tcCap_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = TICK;
                    end
                end
                TICK: begin
                    tick_d    = 1'b1;
                    count_d   = count_q + 1'b1;
                    waitCnt_d = '0;
                    state_d   = WAIT;
                end
                DONE: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            waitCnt_q <= '0;
            tcCap_q   <= '0;
            count_q   <= '0;
            clr_q     <= 1'b0;
            tick_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            tcCap_q   <= tcCap_d;
            count_q   <= count_d;
            clr_q     <= clr_d;
            tick_q    <= tick_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign cnt_clr  = clr_q;
    assign cnt_tick = tick_q;
    assign count    = count_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 Parameter: WIDTH, default 4, width of the sequenced counter and of tc/cnt_q/count.
REQ-002 Parameter: SETTLE_CYC, default 3, minimum 2, wait cycles after each clear/tick before the counter is sampled.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: begin a count run; sampled only in IDLE.
REQ-006 The block SHALL have port stop, input, 1 bit: abort the run from any non-IDLE state.
REQ-007 The block SHALL have port tc, input, WIDTH bits: terminal count, captured on an accepted start.
REQ-008 The block SHALL have port cnt_q, input, WIDTH bits: output of the external ripple counter; asynchronous to clk.
REQ-009 The block SHALL have port cnt_clr, output, 1 bit: active-high clear to the counter.
REQ-010 The block SHALL have port cnt_tick, output, 1 bit: one-cycle pulse that serves as the counter clock.
REQ-011 The block SHALL have port count, output, WIDTH bits: shadow count of ticks issued.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse on successful completion.
REQ-014 The block SHALL have port err, output, 1 bit: sticky flag for a counter readback mismatch.

Function
REQ-015 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-016 The FSM SHALL have exactly these states: IDLE, CLEAR, WAIT, CHECK, TICK, DONE.
REQ-017 In IDLE, start=1 with stop=0 SHALL capture tc, clear err and count, and go to CLEAR.
REQ-018 In IDLE, start=1 with stop=1 SHALL leave the block in IDLE (stop wins).
REQ-019 CLEAR SHALL last one cycle with cnt_clr=1, then go to WAIT.
REQ-020 WAIT SHALL last exactly SETTLE_CYC cycles, then go to CHECK.
REQ-021 CHECK SHALL last one cycle and go to DONE if count equals captured tc, otherwise to TICK.
REQ-022 TICK SHALL last one cycle with cnt_tick=1, increment count modulo 2^WIDTH, then go to WAIT.
REQ-023 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-024 Total time from the edge that samples start to the done cycle SHALL be (tc+1)*(SETTLE_CYC+2)+1 clocks.
REQ-025 tc=0: no tick is issued and done occurs SETTLE_CYC+3 clocks after start.
REQ-026 tc=2^WIDTH-1: all 2^WIDTH-1 ticks are issued, and count never wraps before done.
REQ-027 stop in any non-IDLE state SHALL move to IDLE on the next edge, with no done and no further cnt_tick or cnt_clr; count holds its value.
REQ-028 start while busy SHALL be ignored, and tc changes while busy SHALL have no effect.
REQ-029 cnt_clr and cnt_tick SHALL never be high in the same cycle.

Reset
REQ-030 rst low SHALL immediately force state IDLE, count=0, busy=0, done=0, err=0, cnt_clr=0, cnt_tick=0, and synchronizer flops to 0.
REQ-031 Reset asserted mid-run SHALL abort the run with no done pulse; after release the block waits in IDLE for start.

Configuration
REQ-032 Macro CNT_CHECK_EN defined: cnt_q SHALL pass through a 2-flop synchronizer.
REQ-033 With CNT_CHECK_EN defined, in CHECK a synchronized cnt_q not equal to count SHALL set err, skip done, and go to IDLE.
REQ-034 Macro CNT_CHECK_EN undefined: no synchronizer, cnt_q ignored, err tied 0, and CHECK compares count against tc only.

Verification
REQ-035 Scenario: reset, then start with tc=2 and SETTLE_CYC=3 -> one cnt_clr, two cnt_tick pulses 5 clocks apart, done exactly 16 clocks after start, count=2, err=0.
REQ-036 Scenario: start with tc=0 -> cnt_clr only, no cnt_tick, done 6 clocks after start, count=0.
REQ-037 Scenario: start with tc=5, stop asserted in the cycle after the 3rd tick -> IDLE next edge, count=3, no done, no further ticks.
REQ-038 Scenario: start and stop both high in IDLE -> remains IDLE; start pulse during a run with tc=4 -> ignored, done after 26 clocks.
REQ-039 Scenario (CNT_CHECK_EN defined): counter model stuck at 0, tc=3 -> err=1 at the second CHECK, no done, err held until next start.
REQ-040 Scenario: rst pulled low asynchronously mid-WAIT with tc=7 -> all outputs 0 immediately; after release, start with tc=1 -> done 11 clocks after start.
